touch_stroke_rasterizer: RTL and testbench
==========================================

Name: touch_stroke_rasterizer

Overview:
- Sits between the FT6206 touch controller output and the VRAM write port.
- Turns successive touch samples into continuous strokes: draws a Bresenham line from the previous pen position to each new one, one pixel per cycle.
- Emits VRAM write address/data/enable, so fast finger motion no longer leaves gaps between sampled points.
- The VRAM arbiter gates the block with `ena` while the clear sweep owns the write port.

Parameters:
- DISPLAY_WIDTH, 240, pixels per row; also the address multiplier.
- DISPLAY_HEIGHT, 320, rows.
- VRAM_L, DISPLAY_WIDTH*DISPLAY_HEIGHT, VRAM depth.
- PEN_COLOR, 16'hFFFF, RGB565 value written for every stroke pixel.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- ena  in  1  1 = may sample and write; 0 = freeze all state, wr_ena forced 0.
- touch_valid  in  1  level; 1 while a finger is present.
- touch_x  in  9  touch column.
- touch_y  in  9  touch row.
- wr_ena  out  1  registered VRAM write strobe.
- wr_addr  out  $clog2(VRAM_L)  registered address, y*DISPLAY_WIDTH+x.
- wr_data  out  16  registered pixel colour.
- busy  out  1  high in SETUP/DRAW.
- pen_down  out  1  high while a stroke is in progress.

Behaviour:
- Reset values: wr_ena=0, wr_addr=0, wr_data=0, busy=0, pen_down=0, state=IDLE, last point=(0,0).
- States are IDLE, SETUP, DRAW. Transitions happen only on cycles with ena=1; with ena=0, state, counters, err and position hold and wr_ena=0.
- IDLE, touch_valid=0: pen_down<=0.
- IDLE, sample discarded when touch_valid=1 and either:
  - touch_x>=DISPLAY_WIDTH or touch_y>=DISPLAY_HEIGHT (pen state unchanged); or
  - pen_down=1 and the sample equals the last point (no redundant writes).
- IDLE, sample accepted otherwise:
  - Latch the end point P1.
  - Start point P0 is the last point if pen_down=1, else P1 (single dot).
  - Set pen_down<=1, go to SETUP.
- SETUP (1 cycle), 11-bit signed arithmetic:
  - dx=|x1-x0|, dy=-|y1-y0|, sx/sy=±1, err=dx+dy.
  - Current position cur=P0. Go to DRAW.
- DRAW, each cycle:
  - Register wr_ena=1, wr_addr=cur.y*DISPLAY_WIDTH+cur.x, wr_data=PEN_COLOR.
  - If cur==P1: last point<=P1, go to IDLE.
  - Else compute e2=2*err:
    - if e2>=dy: err+=dy, cur.x+=sx;
    - if e2<=dx: err+=dx, cur.y+=sy;
    - both updates use the pre-update err.
- Both endpoints are written. A segment writes max(|dx|,|dy|)+1 pixels in that many consecutive enabled cycles.
- Latency: sample accepted at edge N → first wr_ena high after edge N+2.
- Touch changes during SETUP/DRAW are ignored. The next sample is taken in IDLE, so intermediate controller updates may be skipped.
- Finger lift mid-line: the line completes, then pen_down clears in IDLE.
- rst mid-line: abort immediately, all outputs return to reset values the next cycle, and the next touch starts a new dot.
- No multiplier on the critical path beyond a constant multiply by DISPLAY_WIDTH. The address is always < VRAM_L by construction.

Optional Feature:
- Macro: TOUCH_STROKE_BRUSH_PLUS_EN.
- Defined: each line pixel is stamped as a 5-pixel plus, in the order centre, x-1, x+1, y-1, y+1.
  - A sub-counter adds 4 cycles per line pixel.
  - Neighbours outside 0..DISPLAY_WIDTH-1 / 0..DISPLAY_HEIGHT-1 are skipped: that cycle gives wr_ena=0 and still consumes a sub-step.
- Undefined: 1-pixel pen and the timing above.

Test Plan:
- Single dot: pen up, touch (10,20) held → exactly one write, addr 4810, data 16'hFFFF, then pen_down=1; holding the same point gives no further writes.
- Horizontal stroke: dot at (0,0), then (5,0) → six consecutive writes with addrs 0,1,2,3,4,5; busy falls the cycle after the last.
- Diagonal: after (0,0), touch (3,3) → addrs 0,241,482,723. Steep case, (0,0)→(1,3): addrs 0,240,481,721.
- Stall: drop ena for 3 cycles mid-segment → wr_ena=0 for those cycles; the remaining addresses resume in order with none lost or duplicated.
- Out of range / pen up:
  - Touch (240,5) → no write, pen state unchanged.
  - Lift, then touch (50,50) after a stroke ending at (10,10) → a single write at 12050, with no connecting line.
- Reset mid-line: assert rst during a 100-pixel segment → wr_ena=0 the next cycle and pen_down=0; the next touch produces a single dot.

Source files
------------

// File: rtl/touch_stroke_rasterizer.sv
// touch_stroke_rasterizer
// Converts successive touch samples into continuous pen strokes. Each accepted
// sample is joined to the previous pen position with a Bresenham line. The
// line is emitted one pixel per enabled cycle as VRAM write transactions.
//
// Optional feature macro: TOUCH_STROKE_BRUSH_PLUS_EN
//   When defined, each line pixel is stamped as a 5-pixel plus, in the order
//   centre, x-1, x+1, y-1, y+1. Off-screen neighbours still take a cycle but
//   produce no write. When undefined, the pen is a single pixel.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   ena         1 = may sample and write; 0 = hold all state, wr_ena forced 0
//   touch_valid level, high while a finger is present
//   touch_x     touch column (9 bits)
//   touch_y     touch row (9 bits)
//   wr_ena      registered VRAM write strobe
//   wr_addr     registered VRAM address, y*DISPLAY_WIDTH+x
//   wr_data     registered pixel colour
//   busy        high while a segment is being set up or drawn
//   pen_down    high while a stroke is in progress
module touch_stroke_rasterizer #(
    parameter int          DISPLAY_WIDTH  = 240,
    parameter int          DISPLAY_HEIGHT = 320,
    parameter int          VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    parameter logic [15:0] PEN_COLOR      = 16'hFFFF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic                      touch_valid,
    input  logic [8:0]                touch_x,
    input  logic [8:0]                touch_y,
    output logic                      wr_ena,
    output logic [$clog2(VRAM_L)-1:0] wr_addr,
    output logic [15:0]               wr_data,
    output logic                      busy,
    output logic                      pen_down
);

    localparam int AW = $clog2(VRAM_L);
    localparam logic [8:0] X_LIM = 9'(DISPLAY_WIDTH);
    localparam logic [8:0] Y_LIM = 9'(DISPLAY_HEIGHT);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

    state_t state, next_state;

    logic [8:0] last_x, last_y;
    logic [8:0] x0, y0, x1, y1;
    logic [8:0] cur_x, cur_y;
    logic signed [10:0] dx, dy, err;
    logic sx_neg, sy_neg;

    logic in_range, same_pt, accept;
    logic signed [10:0] dx_raw, dy_raw, dx_abs, dy_abs;
    logic signed [11:0] e2, dx12, dy12;
    logic step_x, step_y, at_end;
    logic signed [10:0] err_next;
    logic [8:0] cur_x_next, cur_y_next;

    logic [8:0] stamp_x, stamp_y;
    logic stamp_ok, step_done;
    logic [AW-1:0] pix_addr;

`ifdef TOUCH_STROKE_BRUSH_PLUS_EN
    localparam logic [8:0] X_MAX = 9'(DISPLAY_WIDTH - 1);
    localparam logic [8:0] Y_MAX = 9'(DISPLAY_HEIGHT - 1);
    logic [2:0] sub;
`endif

    assign busy = (state != IDLE);

    // Sample qualification: a sample is only worth drawing if it lies on
    // screen and, during a stroke, actually moves the pen.
    always_comb begin
        in_range = (touch_x < X_LIM) && (touch_y < Y_LIM);
        same_pt  = pen_down && (touch_x == last_x) && (touch_y == last_y);
        accept   = touch_valid && in_range && !same_pt;
    end

    // Bresenham setup and step. Zero-extended to 11 bits so that the
    // differences of two 9-bit coordinates never overflow. e2 is one bit
    // wider again so that 2*err is exact.
    always_comb begin
        dx_raw = $signed({2'b00, x1}) - $signed({2'b00, x0});
        dy_raw = $signed({2'b00, y1}) - $signed({2'b00, y0});
        dx_abs = dx_raw[10] ? -dx_raw : dx_raw;
        dy_abs = dy_raw[10] ? -dy_raw : dy_raw;

        e2     = $signed({err, 1'b0});
        dx12   = $signed({dx[10], dx});
        dy12   = $signed({dy[10], dy});
        step_x = (e2 >= dy12);
        step_y = (e2 <= dx12);

        err_next   = err + (step_x ? dy : 11'sd0) + (step_y ? dx : 11'sd0);
        cur_x_next = step_x ? (sx_neg ? cur_x - 9'd1 : cur_x + 9'd1) : cur_x;
        cur_y_next = step_y ? (sy_neg ? cur_y - 9'd1 : cur_y + 9'd1) : cur_y;
        at_end     = (cur_x == x1) && (cur_y == y1);
    end

    // Pixel actually written this cycle. With the brush, a sub-step counter
    // walks the plus shape and the line only advances after the last arm.
    always_comb begin
        stamp_x   = cur_x;
        stamp_y   = cur_y;
        stamp_ok  = 1'b1;
        step_done = 1'b1;
`ifdef TOUCH_STROKE_BRUSH_PLUS_EN
        step_done = (sub == 3'd4);
        case (sub)
            3'd1: begin stamp_x = cur_x - 9'd1; stamp_ok = (cur_x != 9'd0);  end
            3'd2: begin stamp_x = cur_x + 9'd1; stamp_ok = (cur_x != X_MAX); end
            3'd3: begin stamp_y = cur_y - 9'd1; stamp_ok = (cur_y != 9'd0);  end
            3'd4: begin stamp_y = cur_y + 9'd1; stamp_ok = (cur_y != Y_MAX); end
            default: ;
        endcase
`endif
        pix_addr = AW'(stamp_y) * AW'(DISPLAY_WIDTH) + AW'(stamp_x);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (ena) begin
            case (state)
                IDLE:    if (accept) next_state = SETUP;
                SETUP:   next_state = DRAW;
                DRAW:    if (at_end && step_done) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ena   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            pen_down <= 1'b0;
            last_x   <= '0;
            last_y   <= '0;
            x0       <= '0;
            y0       <= '0;
            x1       <= '0;
            y1       <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            dx       <= '0;
            dy       <= '0;
            err      <= '0;
            sx_neg   <= 1'b0;
            sy_neg   <= 1'b0;
`ifdef TOUCH_STROKE_BRUSH_PLUS_EN
            sub      <= '0;
`endif
        end else begin
            wr_ena <= 1'b0;
            if (ena) begin
                case (state)
                    IDLE: begin
                        if (!touch_valid) begin
                            pen_down <= 1'b0;
                        end else if (accept) begin
                            x1       <= touch_x;
                            y1       <= touch_y;
                            // Pen up: start and end coincide, giving a dot.
                            x0       <= pen_down ? last_x : touch_x;
                            y0       <= pen_down ? last_y : touch_y;
                            pen_down <= 1'b1;
                        end
                    end
                    SETUP: begin
                        dx     <= dx_abs;
                        dy     <= -dy_abs;
                        err    <= dx_abs - dy_abs;
                        sx_neg <= dx_raw[10];
                        sy_neg <= dy_raw[10];
                        cur_x  <= x0;
                        cur_y  <= y0;
`ifdef TOUCH_STROKE_BRUSH_PLUS_EN
                        sub    <= '0;
`endif
                    end
                    DRAW: begin
                        wr_ena <= stamp_ok;
                        if (stamp_ok) begin
                            wr_addr <= pix_addr;
                            wr_data <= PEN_COLOR;
                        end
`ifdef TOUCH_STROKE_BRUSH_PLUS_EN
                        sub <= step_done ? 3'd0 : sub + 3'd1;
`endif
                        if (step_done) begin
                            if (at_end) begin
                                last_x <= x1;
                                last_y <= y1;
                            end else begin
                                err   <= err_next;
                                cur_x <= cur_x_next;
                                cur_y <= cur_y_next;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_touch_stroke_rasterizer.sv
// Testbench for touch_stroke_rasterizer (default single-pixel pen build).
// Expected write addresses are pushed to a scoreboard queue when a touch
// sample is driven; a monitor pops and compares them as the DUT writes.
module tb_touch_stroke_rasterizer;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        touch_valid;
    logic [8:0]  touch_x;
    logic [8:0]  touch_y;
    logic        wr_ena;
    logic [16:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        pen_down;

    int total_checks;
    int bad_checks;
    int exp_q[$];

    touch_stroke_rasterizer dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .touch_valid (touch_valid),
        .touch_x     (touch_x),
        .touch_y     (touch_y),
        .wr_ena      (wr_ena),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .pen_down    (pen_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive a new touch sample just after a rising edge.
    task automatic applyStimulus(input int x, input int y, input logic valid);
        @(posedge clk);
        #1;
        touch_x     = 9'(x);
        touch_y     = 9'(y);
        touch_valid = valid;
    endtask

    task automatic liftPen();
        applyStimulus(0, 0, 1'b0);
        repeat (3) @(posedge clk);
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", (n >= 400) ? 1 : 0, 0);
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard monitor: every write must match the next expected address.
    always @(negedge clk) begin
        if (wr_ena === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_wr", int'(wr_ena), 0);
            end else begin
                checkOutput("wr_addr", int'(wr_addr), exp_q.pop_front());
                checkOutput("wr_data", int'(wr_data), 16'hFFFF);
            end
        end
    end

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        rst          = 1'b1;
        ena          = 1'b1;
        touch_valid  = 1'b0;
        touch_x      = '0;
        touch_y      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_wr_ena",   int'(wr_ena),   0);
        checkOutput("rst_wr_addr",  int'(wr_addr),  0);
        checkOutput("rst_wr_data",  int'(wr_data),  0);
        checkOutput("rst_busy",     int'(busy),     0);
        checkOutput("rst_pen_down", int'(pen_down), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single dot, with first-write latency: accept at N, write after N+2.
        exp_q.push_back(4810);
        applyStimulus(10, 20, 1'b1);
        @(posedge clk); @(negedge clk);
        checkOutput("dot_busy_setup", int'(busy), 1);
        checkOutput("dot_lat_n",      int'(wr_ena), 0);
        @(posedge clk); @(negedge clk);
        checkOutput("dot_lat_n1",     int'(wr_ena), 0);
        @(posedge clk); @(negedge clk);
        checkOutput("dot_lat_n2",     int'(wr_ena), 1);
        waitDrain();
        repeat (10) @(posedge clk);
        checkOutput("dot_pen_down", int'(pen_down), 1);

        // Horizontal stroke.
        liftPen();
        checkOutput("lift_pen_down", int'(pen_down), 0);
        exp_q.push_back(0);
        applyStimulus(0, 0, 1'b1);
        waitDrain();
        for (int i = 0; i <= 5; i++) exp_q.push_back(i);
        applyStimulus(5, 0, 1'b1);
        waitDrain();
        checkOutput("horiz_busy_low", int'(busy), 0);

        // Diagonal stroke.
        liftPen();
        exp_q.push_back(0);
        applyStimulus(0, 0, 1'b1);
        waitDrain();
        exp_q.push_back(0); exp_q.push_back(241);
        exp_q.push_back(482); exp_q.push_back(723);
        applyStimulus(3, 3, 1'b1);
        waitDrain();

        // Steep stroke.
        liftPen();
        exp_q.push_back(0);
        applyStimulus(0, 0, 1'b1);
        waitDrain();
        exp_q.push_back(0); exp_q.push_back(240);
        exp_q.push_back(481); exp_q.push_back(721);
        applyStimulus(1, 3, 1'b1);
        waitDrain();

        // Stall for three cycles in the middle of a segment.
        liftPen();
        exp_q.push_back(24000);
        applyStimulus(0, 100, 1'b1);
        waitDrain();
        for (int i = 0; i <= 20; i++) exp_q.push_back(24000 + i);
        applyStimulus(20, 100, 1'b1);
        repeat (6) @(posedge clk);
        #1 ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            checkOutput("stall_wr_ena", int'(wr_ena), 0);
        end
        ena = 1'b1;
        waitDrain();

        // Off-screen sample is ignored and leaves the pen untouched.
        applyStimulus(240, 5, 1'b1);
        repeat (8) @(posedge clk);
        checkOutput("oor_pen_down", int'(pen_down), 1);
        applyStimulus(20, 100, 1'b1);
        repeat (8) @(posedge clk);

        // Lift between strokes: no connecting line.
        liftPen();
        exp_q.push_back(2410);
        applyStimulus(10, 10, 1'b1);
        waitDrain();
        liftPen();
        exp_q.push_back(12050);
        applyStimulus(50, 50, 1'b1);
        waitDrain();

        // Reset in the middle of a 100-pixel segment.
        liftPen();
        exp_q.push_back(48000);
        applyStimulus(0, 200, 1'b1);
        waitDrain();
        for (int i = 0; i < 100; i++) exp_q.push_back(48000 + i);
        applyStimulus(99, 200, 1'b1);
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); @(negedge clk);
        checkOutput("midrst_wr_ena",   int'(wr_ena),   0);
        checkOutput("midrst_pen_down", int'(pen_down), 0);
        checkOutput("midrst_busy",     int'(busy),     0);
        exp_q.delete();
        exp_q.push_back(48099);
        @(posedge clk);
        #1 rst = 1'b0;
        waitDrain();
        repeat (10) @(posedge clk);

        checkOutput("queue_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
